apb_slave_regs: RTL and testbench

//  APB (v3) completer on the downstream side of apb_master. It holds a small 32-bit register bank.
//  It exposes a read-only input port word at 0x04 and a read/write output word at 0x00.
//  It inserts a programmable number of wait states and flags bad accesses with PSLVERR.
//  It keeps saturating write and error counters for visibility.

---
 rtl/apb_pkg.sv | 14 +
 rtl/sat_counter16.sv | 16 +
 rtl/apb_slave_regs.sv | 98 +++++++++
 tb/tb_apb_slave_regs.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: address map, FSM states, counter width and error decode shared by apb_slave_regs
package apb_pkg;
    localparam logic [7:0] ADDR_DATA_OUT = 8'h00;
    localparam logic [7:0] ADDR_DATA_IN  = 8'h04;
    localparam logic [7:0] ADDR_CTRL     = 8'h08;
    localparam logic [7:0] ADDR_STATUS   = 8'h0C;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    // Misaligned, out of range, or a write to a read-only word
    function automatic logic is_err(input logic [7:0] a, input logic wr, input int nregs);
        return (a[1:0] != 2'b00) || (int'(a[7:2]) >= nregs) ||
               (wr && (a == ADDR_DATA_IN || a == ADDR_STATUS));
    endfunction
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: counter that sticks at all-ones, with synchronous clear
module sat_counter16
    import apb_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    // Count up on inc, hold once full, clr takes priority
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + CNT_W'(1);
endmodule

// File: rtl/apb_slave_regs.sv
// apb_slave_regs: APB3 completer with a small register bank, wait states and error counters
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int NREGS       = 8,
    parameter int WAIT_CYCLES = 1
)(
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        wr_pulse
);
    localparam int AW = $clog2(NREGS);
    state_t            state, state_nx;
    logic [7:0]        addr_q, cur_addr, cnt, cnt_nx;
    logic              wr_q, cur_wr, cur_err, setup, enter_resp, complete, wr_ok;
    logic [31:0]       rd_val;
    logic [31:0]       regs [NREGS];
    logic [CNT_W-1:0]  wr_cnt, err_cnt;

    // Decode against the live bus in IDLE, the captured setup afterwards; next-state logic
    always_comb begin
        cur_addr = (state == IDLE) ? PADDR : addr_q;
        cur_wr = (state == IDLE) ? PWRITE : wr_q;
        cur_err = is_err(cur_addr, cur_wr, NREGS);
        setup = (state == IDLE) && PSEL && !PENABLE;
        state_nx = state;
        cnt_nx = cnt;
        case (state)
            IDLE: if (setup) begin
                state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
                cnt_nx = 8'(WAIT_CYCLES);
            end
            WAIT: if (!PSEL) state_nx = IDLE;
                  else if (cnt == 8'd1) state_nx = RESP;
                  else cnt_nx = cnt - 8'd1;
            default: state_nx = IDLE;
        endcase
        enter_resp = (state_nx == RESP) && (state != RESP);
        complete = (state == RESP) && PSEL && PENABLE;
        wr_ok = complete && wr_q && !cur_err;
        rd_val = (cur_err || cur_wr) ? 32'h0 :
                 (cur_addr == ADDR_DATA_IN) ? data_in :
                 (cur_addr == ADDR_STATUS) ? {err_cnt, wr_cnt} : regs[cur_addr[AW+1:2]];
    end

    // State, wait counter and setup-phase capture
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            addr_q <= '0;
            wr_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (setup) begin
                addr_q <= PADDR;
                wr_q <= PWRITE;
            end
        end

    assign PREADY = (state == RESP);

    // Response is loaded on entry to RESP and cleared on the cycle after
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            PRDATA <= '0;
            PSLVERR <= 1'b0;
        end else begin
            PRDATA <= enter_resp ? rd_val : 32'h0;
            PSLVERR <= enter_resp && cur_err;
        end

    // Register bank commit at the completing edge; CTRL keeps only irq_en
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            wr_pulse <= 1'b0;
        end else begin
            if (wr_ok) regs[addr_q[AW+1:2]] <= (addr_q == ADDR_CTRL) ? {31'b0, PWDATA[0]} : PWDATA;
            wr_pulse <= wr_ok && (addr_q == ADDR_DATA_OUT) && regs[2][0];
        end

    assign data_out = regs[0];

    sat_counter16 u_wr_cnt (.clk(clk), .rstn(rstn), .inc(wr_ok), .clr(1'b0), .count(wr_cnt));
    sat_counter16 u_err_cnt (.clk(clk), .rstn(rstn), .inc(complete && cur_err), .clr(1'b0), .count(err_cnt));
endmodule

// File: tb/tb_apb_slave_regs.sv
// tb_apb_slave_regs: table-driven and sequence checks of apb_slave_regs with a response scoreboard
module tb_apb_slave_regs;
    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk, rstn;
    logic [7:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, data_in;
    logic        which;
    logic        psel_a, psel_b;
    logic [31:0] prdata_a, prdata_b, dout_a, dout_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b, pulse_a, pulse_b;
    logic [31:0] cur_prdata, cur_dout;
    logic        cur_ready, cur_err;
    int          checks, failures;
    exp_t        sb[$];
    vec_t        vecs[16];
    logic [31:0] rd;

    assign psel_a = PSEL && !which;
    assign psel_b = PSEL && which;
    assign cur_prdata = which ? prdata_b : prdata_a;
    assign cur_ready = which ? pready_b : pready_a;
    assign cur_err = which ? pslverr_b : pslverr_a;
    assign cur_dout = which ? dout_b : dout_a;

    apb_slave_regs #(.NREGS(8), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rstn(rstn), .PADDR(PADDR), .PSEL(psel_a), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a),
        .data_in(data_in), .data_out(dout_a), .wr_pulse(pulse_a));

    apb_slave_regs #(.NREGS(8), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rstn(rstn), .PADDR(PADDR), .PSEL(psel_b), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b),
        .data_in(data_in), .data_out(dout_b), .wr_pulse(pulse_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Setup now (caller is just after a rising edge), then access until PREADY; returns just after the completing edge
    task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input string nm,
                        output logic [31:0] rdata);
        int waits;
        exp_t e;
        PADDR = a;
        PWRITE = w;
        PWDATA = ~wd;
        PSEL = 1'b1;
        PENABLE = 1'b0;
        sb.push_back('{exp_rd, exp_err});
        @(posedge clk); #1;
        PENABLE = 1'b1;
        PWDATA = wd;
        waits = 0;
        @(negedge clk);
        while (!cur_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        chk({nm, " wait_cycles"}, 32'(waits), which ? 32'd3 : 32'd1);
        e = sb.pop_front();
        chk({nm, " prdata"}, cur_prdata, e.rd);
        chk({nm, " pslverr"}, 32'(cur_err), 32'(e.err));
        rdata = cur_prdata;
        @(posedge clk); #1;
    endtask

    task automatic go_idle();
        PSEL = 1'b0;
        PENABLE = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        which = 1'b0;
        rstn = 1'b0;
        PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
        data_in = 32'hDEADBEEF;
        vecs = '{
            '{8'h00, 1'b0, 32'h0,        32'h0,        1'b0},
            '{8'h04, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0},
            '{8'h08, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b0},
            '{8'h08, 1'b0, 32'h0,        32'h00000001, 1'b0},
            '{8'h10, 1'b1, 32'hA5A5A5A5, 32'h0,        1'b0},
            '{8'h10, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0},
            '{8'h1C, 1'b1, 32'h0BADF00D, 32'h0,        1'b0},
            '{8'h1C, 1'b0, 32'h0,        32'h0BADF00D, 1'b0},
            '{8'h0C, 1'b0, 32'h0,        32'h00000003, 1'b0},
            '{8'h04, 1'b1, 32'h00000055, 32'h0,        1'b1},
            '{8'h22, 1'b0, 32'h0,        32'h0,        1'b1},
            '{8'h20, 1'b0, 32'h0,        32'h0,        1'b1},
            '{8'h0C, 1'b1, 32'h00000001, 32'h0,        1'b1},
            '{8'h01, 1'b0, 32'h0,        32'h0,        1'b1},
            '{8'h0C, 1'b0, 32'h0,        32'h00050003, 1'b0},
            '{8'h04, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0}
        };
        #1;
        chk("reset prdata", prdata_a, 32'h0);
        chk("reset pready", 32'(pready_a), 32'h0);
        chk("reset pslverr", 32'(pslverr_a), 32'h0);
        chk("reset data_out", dout_a, 32'h0);
        chk("reset wr_pulse", 32'(pulse_a), 32'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;

        // Back-to-back table on the single-wait instance
        for (int i = 0; i < 16; i++)
            xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err,
                 $sformatf("vec%0d", i), rd);

        // DATA_OUT write with irq_en set: data lands and wr_pulse lasts one cycle
        xfer(8'h00, 1'b1, 32'h12345678, 32'h0, 1'b0, "wr_dout", rd);
        chk("wr_dout data_out", dout_a, 32'h12345678);
        chk("wr_dout wr_pulse high", 32'(pulse_a), 32'h1);
        go_idle();
        @(posedge clk); #1;
        chk("wr_dout wr_pulse low", 32'(pulse_a), 32'h0);
        chk("idle pready", 32'(pready_a), 32'h0);
        xfer(8'h0C, 1'b0, 32'h0, 32'h00050004, 1'b0, "status2", rd);

        // Read DATA_IN then immediately write it to DATA_OUT
        data_in = 32'hCAFEF00D;
        xfer(8'h04, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "b2b_rd", rd);
        xfer(8'h00, 1'b1, rd, 32'h0, 1'b0, "b2b_wr", rd);
        chk("b2b data_out", dout_a, 32'hCAFEF00D);

        // irq_en cleared: DATA_OUT write without a pulse
        xfer(8'h08, 1'b1, 32'h0, 32'h0, 1'b0, "ctrl_off", rd);
        xfer(8'h00, 1'b1, 32'h00000077, 32'h0, 1'b0, "wr_nopulse", rd);
        chk("nopulse wr_pulse", 32'(pulse_a), 32'h0);
        chk("nopulse data_out", dout_a, 32'h00000077);
        go_idle();
        @(posedge clk); #1;

        // Three-wait instance: one good write, then an abort during WAIT
        which = 1'b1;
        xfer(8'h10, 1'b1, 32'h11111111, 32'h0, 1'b0, "b_wr", rd);
        PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 32'hAAAA5555; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(posedge clk); #1;
        chk("abort pready in wait", 32'(pready_b), 32'h0);
        go_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("abort data_out", dout_b, 32'h0);
        xfer(8'h0C, 1'b0, 32'h0, 32'h00000001, 1'b0, "abort_status", rd);
        xfer(8'h10, 1'b0, 32'h0, 32'h11111111, 1'b0, "b_scratch", rd);
        go_idle();
        @(posedge clk); #1;

        // Reset while a DATA_OUT write waits
        which = 1'b0;
        PADDR = 8'h00; PWRITE = 1'b1; PWDATA = 32'h0000FFFF; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        PWDATA = 32'hFFFF0000;
        #2 rstn = 1'b0;
        #1;
        chk("rst_wait pready", 32'(pready_a), 32'h0);
        chk("rst_wait data_out", dout_a, 32'h0);
        go_idle();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_wait no commit", dout_a, 32'h0);

        // Reset while in RESP of a read: PREADY and PRDATA drop at once
        PADDR = 8'h04; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp pready before", 32'(pready_a), 32'h1);
        rstn = 1'b0;
        #1;
        chk("rst_resp pready", 32'(pready_a), 32'h0);
        chk("rst_resp prdata", prdata_a, 32'h0);
        go_idle();
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Normal operation after reset; everything cleared
        xfer(8'h0C, 1'b0, 32'h0, 32'h0, 1'b0, "post_status", rd);
        xfer(8'h10, 1'b0, 32'h0, 32'h0, 1'b0, "post_scratch", rd);
        xfer(8'h08, 1'b0, 32'h0, 32'h0, 1'b0, "post_ctrl", rd);
        xfer(8'h00, 1'b1, 32'h00000005, 32'h0, 1'b0, "post_wr", rd);
        xfer(8'h00, 1'b0, 32'h0, 32'h00000005, 1'b0, "post_rd", rd);
        go_idle();
        @(posedge clk); #1;
        chk("scoreboard empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
